// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined array multiplier: row partitioning and stage payload sizing.
package mult_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned rows_per_stage(input int unsigned w, input int unsigned s);
        return (w + s - 1) / s;
    endfunction

    // First row owned by stage k (clamped so trailing stages may be short or empty)
    function automatic int unsigned row_bound(input int unsigned w, input int unsigned rps,
                                              input int unsigned k);
        return (k * rps < w) ? k * rps : w;
    endfunction

    // Stage payload {partial sum, extended multiplicand, signed}
    function automatic int unsigned stage_payload_w(input int unsigned w);
        return 2 * w + 2 * w + 1;
    endfunction

endpackage

// File: rtl/pipelined_array_multiplier_pp_row_stage.sv
// Combinational partial-product accumulator for rows [ROW_LO, ROW_HI); the last stage
// also folds in the sign-extension rows of a negative signed multiplier.
module pp_row_stage
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ROW_LO   = 0,
    parameter int unsigned ROW_HI   = 8,
    parameter bit          EXT_ROWS = 1'b0
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] a_ext_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] acc_c_o
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned IW = clog2(WIDTH);

    logic [PW-1:0] sum;
    logic          unused_ok;

    always_comb begin
        sum = acc_i;
        for (int i = int'(ROW_LO); i < int'(ROW_HI); i++) begin
            if (b_i[IW'(i)]) begin
                sum = sum + (a_ext_i << i);
            end
        end
        // Rows WIDTH..2*WIDTH-1 of a sign-extended multiplier all equal its MSB
        if (EXT_ROWS && signed_i && b_i[WIDTH-1]) begin
            for (int i = int'(WIDTH); i < int'(PW); i++) begin
                sum = sum + (a_ext_i << i);
            end
        end
        acc_c_o = sum;
    end

    // Each stage only looks at its own slice of the multiplier
    assign unused_ok = ^{b_i, signed_i};

endmodule

// File: rtl/pipelined_array_multiplier.sv
// WIDTH x WIDTH array multiplier with partial-product rows spread across STAGES register
// stages, valid/ready on both sides, backpressure that collapses bubbles, and flush.
module pipelined_array_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_signed
);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned PLW = stage_payload_w(WIDTH);
    localparam int unsigned RPS = rows_per_stage(WIDTH, STAGES);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] load_c;
    logic [STAGES-1:0] sgn_in;
    logic [PLW-1:0]    pay_q   [STAGES];
    logic [PLW-1:0]    pay_d   [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [PW-1:0]     acc_in  [STAGES];
    logic [PW-1:0]     a_in    [STAGES];
    logic [PW-1:0]     acc_sum [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = row_bound(WIDTH, RPS, k);
        localparam int unsigned HI = row_bound(WIDTH, RPS, k + 1);

        if (k == 0) begin : g_head
            assign valid_d[k] = in_valid;
            assign acc_in[k]  = '0;
            assign a_in[k]    = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                                          : {{WIDTH{1'b0}}, in_a};
            assign sgn_in[k]  = in_signed;
            assign b_in[k]    = in_b;
        end else begin : g_body
            assign valid_d[k] = valid_q[k-1];
            assign acc_in[k]  = pay_q[k-1][PLW-1 -: PW];
            assign a_in[k]    = pay_q[k-1][PW:1];
            assign sgn_in[k]  = pay_q[k-1][0];
            assign b_in[k]    = b_q[k-1];
        end

        // A stage can take new data unless it and every stage after it are full and stalled
        assign load_c[k] = out_ready | ~(&valid_q[STAGES-1:k]);

        pp_row_stage #(
            .WIDTH    (WIDTH),
            .ROW_LO   (LO),
            .ROW_HI   (HI),
            .EXT_ROWS (k == STAGES - 1)
        ) u_rows (
            .acc_i    (acc_in[k]),
            .a_ext_i  (a_in[k]),
            .b_i      (b_in[k]),
            .signed_i (sgn_in[k]),
            .acc_c_o  (acc_sum[k])
        );

        assign pay_d[k] = {acc_sum[k], a_in[k], sgn_in[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                pay_q[k] <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load_c[k]) begin
                    valid_q[k] <= valid_d[k];
                    pay_q[k]   <= pay_d[k];
                    b_q[k]     <= b_in[k];
                end
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    assign in_ready    = load_c[0];
    assign out_valid   = valid_q[STAGES-1];
    assign out_product = pay_q[STAGES-1][PLW-1 -: PW];
    assign out_signed  = pay_q[STAGES-1][0];

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench: directed vector table, streaming with backpressure, flush, reset, random.
module tb_pipelined_array_multiplier;
    localparam int unsigned W  = 8;
    localparam int unsigned S  = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_product;
    logic          out_signed;

    pipelined_array_multiplier #(.WIDTH(W), .STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_signed  (out_signed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] prod;
        logic          sg;
        int            cyc;
        logic          lat;
    } exp_t;

    typedef struct {
        logic          sg;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] prod;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[12];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            ormode = 0;
    logic          lat_mode = 1'b0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_prod = '0;
    logic          prev_sg = 1'b0;
    logic [PW-1:0] next_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic sg, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic signed [PW-1:0] ps;
        logic        [PW-1:0] pu;
        ps = PW'($signed(a)) * PW'($signed(b));
        pu = PW'(a) * PW'(b);
        return sg ? $unsigned(ps) : pu;
    endfunction

    // One clock cycle: set out_ready, check outputs mid-cycle, update scoreboard, cross the edge
    task automatic step(output bit xf);
        exp_t e;
        if (ormode == 1) out_ready = (cyc % 3 == 0);
        else if (ormode == 2) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_product", 64'(out_product), 64'(prev_prod));
            chk("hold_signed", 64'(out_signed), 64'(prev_sg));
        end
        chk("in_ready", 64'(in_ready), 64'(!(sb.size() == S && !out_ready)));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_output", 64'(out_valid), 64'(0));
            end else if (out_ready) begin
                e = sb.pop_front();
                chk("product", 64'(out_product), 64'(e.prod));
                chk("out_signed", 64'(out_signed), 64'(e.sg));
                if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(S));
            end
        end
        xf = in_valid && in_ready;
        if (xf) sb.push_back('{prod: next_exp, sg: in_signed, cyc: cyc, lat: lat_mode});
        if (flush) sb.delete();
        prev_stall = out_valid && !out_ready && !flush;
        prev_prod  = out_product;
        prev_sg    = out_signed;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit xf;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(xf);
    endtask

    task automatic send(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [PW-1:0] exp);
        bit xf;
        xf = 1'b0;
        in_valid  = 1'b1;
        in_signed = sg;
        in_a      = a;
        in_b      = b;
        next_exp  = exp;
        for (int t = 0; t < 64 && !xf; t++) step(xf);
        if (!xf) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no transfer required=transfer within 64 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit xf;
        in_valid  = 1'b0;
        ormode    = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && sb.size() != 0; t++) step(xf);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
        end
        idle(S + 2);
    endtask

    task automatic send_rand();
        logic         sg;
        logic [W-1:0] a;
        logic [W-1:0] b;
        sg = 1'($urandom_range(0, 1));
        a  = W'($urandom());
        b  = W'($urandom());
        if ($urandom_range(0, 7) == 0) a = (sg != 0) ? 8'h80 : 8'hFF;
        if ($urandom_range(0, 7) == 0) b = (sg != 0) ? 8'h80 : 8'hFF;
        send(sg, a, b, ref_mul(sg, a, b));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit xf;
        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{1'b0, 8'h00, 8'hA5, 16'h0000};
        vecs[2]  = '{1'b0, 8'h80, 8'h02, 16'h0100};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[5]  = '{1'b1, 8'h7F, 8'h81, 16'hC0FF};
        vecs[6]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[7]  = '{1'b0, 8'h7F, 8'h81, 16'h3FFF};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[9]  = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
        vecs[11] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_product", 64'(out_product), 64'(0));
        chk("reset_out_signed", 64'(out_signed), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        // Directed vectors, spaced then back-to-back, latency checked
        out_ready = 1'b1;
        lat_mode  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].prod);
            idle(S + 1);
        end
        for (int i = 0; i < 12; i++) send(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].prod);
        drain();

        // Streaming with out_ready pattern 1,0,0
        lat_mode = 1'b0;
        ormode   = 1;
        for (int i = 0; i < 16; i++) send_rand();
        drain();

        // Flush with three in flight and a transfer in the flush cycle
        lat_mode  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(vecs[i + 3].sg, vecs[i + 3].a, vecs[i + 3].b, vecs[i + 3].prod);
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 8'h11;
        in_b      = 8'h22;
        next_exp  = 16'h0242;
        flush     = 1'b1;
        step(xf);
        flush     = 1'b0;
        idle(S + 2);
        send(1'b0, 8'h0F, 8'h10, 16'h00F0);
        drain();

        // Random handshakes
        lat_mode = 1'b0;
        ormode   = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send_rand();
        end
        drain();

        // Asynchronous reset in the middle of traffic
        ormode = 1;
        for (int i = 0; i < 6; i++) send_rand();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        chk("midreset_out_product", 64'(out_product), 64'(0));
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ormode    = 0;
        out_ready = 1'b1;
        idle(S + 4);
        lat_mode = 1'b1;
        send(1'b1, 8'h80, 8'h80, 16'h4000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
